// File: rtl/avg_pkg.sv
// Shared types and helpers for the multi-channel 2:1 averager.
// Defaults match the scope front-end build (16-bit, 4 channels).
package avg_pkg;

  localparam int VAL_RES_DEF = 16;
  localparam int NUM_CH_DEF  = 4;
  localparam int CH_W_DEF    = $clog2(NUM_CH_DEF);

  typedef logic [CH_W_DEF-1:0]    ch_idx_t;
  typedef logic [VAL_RES_DEF-1:0] val_t;

  // One extra sum bit so (state + x) never wraps; the shift truncates.
  function automatic val_t avg2(input val_t state, input val_t x);
    logic [VAL_RES_DEF:0] sum;
    sum = {1'b0, state} + {1'b0, x};
    return sum[VAL_RES_DEF:1];
  endfunction

endpackage

// File: rtl/avg_rr_arb.sv
// Round-robin arbiter; search starts one past the last granted channel.
// The pointer only moves when a grant is actually taken.
module avg_rr_arb #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  input  logic              adv,
  input  logic              upd,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W-1:0] last;
  logic            found;
  int              j;

  // Wrap-around priority search from last+1
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = (int'(last) + k) % NUM_CH;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = CH_W'(j);
      end
    end
    if (found && en && adv)
      gnt[idx] = 1'b1;
  end

  // Last-grant pointer, reset so channel 0 is searched first
  always_ff @(posedge clk) begin
    if (!rst)
      last <= CH_W'(NUM_CH - 1);
    else if (upd)
      last <= idx;
  end

endmodule

// File: rtl/avg_chan_sched.sv
// Shares one y=(y+x)>>1 datapath across NUM_CH channels.
// Grant -> stage 1 capture -> compute/write-back into output register.
module avg_chan_sched
  import avg_pkg::*;
#(
  parameter  int VAL_RES = VAL_RES_DEF,
  parameter  int NUM_CH  = NUM_CH_DEF,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH*VAL_RES-1:0] in_data,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH-1:0]         clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [VAL_RES-1:0]        out_data,
  output logic [CH_W-1:0]           out_ch
);

  logic               adv;
  logic               hs;
  logic [NUM_CH-1:0]  gnt;
  logic [CH_W-1:0]    idx;

  logic               s1_v;
  logic [CH_W-1:0]    s1_ch;
  logic [VAL_RES-1:0] s1_x;

  logic [VAL_RES-1:0] state [NUM_CH];
  logic [NUM_CH-1:0]  seed;
  logic [VAL_RES-1:0] res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = gnt;
  assign hs       = |gnt;

  avg_rr_arb #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (in_valid),
    .en  (en && rst),
    .adv (adv),
    .upd (hs),
    .gnt (gnt),
    .idx (idx)
  );

  // Stage-2 compute: first sample after reset/clear seeds the filter
  always_comb begin
    res = s1_x;
    if (!seed[s1_ch])
      res = VAL_RES'(avg2(val_t'(state[s1_ch]), val_t'(s1_x)));
  end

  // Pipeline, output register and per-channel state; clr beats write-back
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v      <= 1'b0;
      s1_ch     <= '0;
      s1_x      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      seed      <= '1;
      for (int i = 0; i < NUM_CH; i++)
        state[i] <= '0;
    end else begin
      if (adv) begin
        s1_v      <= hs;
        out_valid <= s1_v;
        if (hs) begin
          s1_ch <= idx;
          s1_x  <= in_data[idx*VAL_RES +: VAL_RES];
        end
        if (s1_v) begin
          out_data     <= res;
          out_ch       <= s1_ch;
          state[s1_ch] <= res;
          seed[s1_ch]  <= 1'b0;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr[i]) begin
          state[i] <= '0;
          seed[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_avg_chan_sched.sv
// Scoreboard bench for avg_chan_sched: handshakes push expectations,
// an output monitor pops and compares.
module tb_avg_chan_sched;

  localparam int VR = 16;
  localparam int NC = 4;

  typedef struct {
    int          ch;
    logic [15:0] data;
    int          cyc;
    bit          lat;
  } exp_t;

  logic           clk = 0;
  logic           rst;
  logic           en;
  logic [NC-1:0]  in_valid;
  logic [NC*VR-1:0] in_data;
  logic [NC-1:0]  in_ready;
  logic [NC-1:0]  clr;
  logic           out_valid;
  logic           out_ready;
  logic [VR-1:0]  out_data;
  logic [1:0]     out_ch;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t sb[$];

  logic [15:0] m_st [NC];
  bit          m_seed [NC];
  bit          use_hand = 0;
  logic [15:0] hand_exp = '0;
  bit          lat_chk = 1;

  avg_chan_sched dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mavg(logic [15:0] a, logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16:1];
  endfunction

  // Reference model: clears first, then accepted samples in order
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      for (int i = 0; i < NC; i++) begin
        m_st[i]   = '0;
        m_seed[i] = 1;
      end
    end else begin
      for (int i = 0; i < NC; i++)
        if (clr[i]) begin
          m_st[i]   = '0;
          m_seed[i] = 1;
        end
      for (int i = 0; i < NC; i++)
        if (in_valid[i] && in_ready[i]) begin
          logic [15:0] x, r;
          exp_t e;
          x = in_data[i*VR +: VR];
          r = m_seed[i] ? x : mavg(m_st[i], x);
          m_st[i]   = r;
          m_seed[i] = 0;
          e.ch   = i;
          e.data = use_hand ? hand_exp : r;
          e.cyc  = cyc;
          e.lat  = lat_chk;
          sb.push_back(e);
        end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_data), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_ch", 32'(out_ch), 32'(e.ch));
        if (e.lat)
          chk("latency", 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  task automatic send(int ch, logic [15:0] v, logic [15:0] hexp, bit hand);
    int n;
    @(posedge clk); #1;
    in_data[ch*VR +: VR] = v;
    in_valid[ch] = 1'b1;
    use_hand = hand;
    hand_exp = hexp;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready[ch]) break;
    end
    chk("send_handshake", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
    use_hand = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1; rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; en = 1; in_valid = '1; in_data = '0;
    clr = '0; out_ready = 1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    @(posedge clk); #1;
    in_valid = '0; rst = 1;

    // 1: channel 0 seed then average
    send(0, 16'd100, 16'd100, 1);
    send(0, 16'd200, 16'd150, 1);
    repeat (4) @(negedge clk);

    // 2: all channels streaming, fresh pointer
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NC; i++) in_data[i*VR +: VR] = 16'(i * 8 + 4);
    in_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_order", 32'(in_ready), 32'(1 << (k % NC)));
      if (k >= 2) chk("no_bubble", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < NC; i++)
        in_data[i*VR +: VR] = 16'((k + 1) * 64 + i * 8 + 4);
    end
    in_valid = '0;
    repeat (4) @(negedge clk);

    // en low blocks grants
    @(posedge clk); #1;
    en = 0; in_valid = 4'b0010;
    repeat (3) begin
      @(negedge clk);
      chk("en_low_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = '0; en = 1;

    // 3: saturation on channel 1
    @(posedge clk); #1; clr = 4'b0010;
    @(posedge clk); #1; clr = '0;
    send(1, 16'hFFFF, 16'hFFFF, 1);
    send(1, 16'hFFFF, 16'hFFFF, 1);
    send(1, 16'h0001, 16'h8000, 1);
    repeat (4) @(negedge clk);

    // 4: output back-pressure with channels 0 and 2
    @(posedge clk); #1;
    lat_chk = 0; out_ready = 0;
    in_data[0*VR +: VR] = 16'h0300;
    in_data[2*VR +: VR] = 16'h0500;
    in_valid = 4'b0101;
    repeat (2) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      if (sb.size() == 0) begin
        chk("stall_sb", 32'd0, 32'd1);
      end else begin
        chk("stall_data", 32'(out_data), 32'(sb[0].data));
        chk("stall_ch", 32'(out_ch), 32'(sb[0].ch));
      end
    end
    @(posedge clk); #1;
    out_ready = 1; lat_chk = 1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    in_valid = '0;
    repeat (5) @(negedge clk);

    // 5: clear coinciding with channel 3 write-back
    @(posedge clk); #1; clr = 4'b1000;
    @(posedge clk); #1; clr = '0;
    send(3, 16'd80, 16'd80, 1);
    send(3, 16'd100, 16'd90, 1);
    clr = 4'b1000;
    @(posedge clk); #1; clr = '0;
    send(3, 16'd40, 16'd40, 1);
    repeat (4) @(negedge clk);

    // 6: reset with a full pipeline
    @(posedge clk); #1;
    lat_chk = 0; out_ready = 0;
    in_data[0*VR +: VR] = 16'd1000;
    in_data[1*VR +: VR] = 16'd2000;
    in_valid = 4'b0011;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 0; in_valid = '0;
    @(posedge clk); #1;
    rst = 1; out_ready = 1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    lat_chk = 1;
    send(0, 16'd500, 16'd500, 1);
    repeat (6) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
